sobel_core: RTL and testbench

- Pipelined Sobel edge detector directly downstream of the 3x3 window fetch stage.
- Consumes the eight neighbour pixels plus the border flag once per pixel-clock enable.
- Produces a saturated 8-bit gradient magnitude and a thresholded edge bit for the VGA output stage.
- Also keeps a per-frame edge-pixel count for debug/statistics readout.

---
 rtl/sobel_pkg.sv | 13 +
 rtl/sobel_axis.sv | 33 +++
 rtl/sobel_core.sv | 90 +++++++++
 tb/tb_sobel_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared widths and the per-stage flag bundle for the Sobel edge detector.
package sobel_pkg;
  localparam int PIX_W   = 8;
  localparam int SUM_W   = 10;
  localparam int GRAD_W  = 11;
  localparam int MAG_MAX = 255;

  typedef struct packed {
    logic valid;
    logic border;
    logic fstart;
  } stage_t;
endpackage

// File: rtl/sobel_axis.sv
// One Sobel axis: weighted 1-2-1 sums on each side, then |pos - neg|, over two stages.
module sobel_axis
  import sobel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] n0,
  input  logic [PIX_W-1:0] n1,
  input  logic [PIX_W-1:0] n2,
  input  logic [PIX_W-1:0] p0,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  output logic [SUM_W-1:0] abs_g
);
  logic [SUM_W-1:0]         sum_p, sum_n;
  logic signed [GRAD_W-1:0] g;

  // Zero-extend both sums so the difference is a true signed value.
  assign g = $signed({1'b0, sum_p}) - $signed({1'b0, sum_n});

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p <= '0;
      sum_n <= '0;
      abs_g <= '0;
    end else if (en) begin
      sum_p <= SUM_W'(p0) + (SUM_W'(p1) << 1) + SUM_W'(p2);
      sum_n <= SUM_W'(n0) + (SUM_W'(n1) << 1) + SUM_W'(n2);
      abs_g <= SUM_W'(g[GRAD_W-1] ? -g : g);
    end
  end
endmodule

// File: rtl/sobel_core.sv
// Three-stage Sobel magnitude with saturation, threshold and per-frame edge counter.
module sobel_core #(
  parameter int PIX_W  = sobel_pkg::PIX_W,
  parameter int THRESH = 64,
  parameter int CNT_W  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             in_valid,
  input  logic             in_border,
  input  logic [PIX_W-1:0] pix_0,
  input  logic [PIX_W-1:0] pix_1,
  input  logic [PIX_W-1:0] pix_2,
  input  logic [PIX_W-1:0] pix_3,
  input  logic [PIX_W-1:0] pix_5,
  input  logic [PIX_W-1:0] pix_6,
  input  logic [PIX_W-1:0] pix_7,
  input  logic [PIX_W-1:0] pix_8,
  input  logic             frame_start,
  output logic             out_valid,
  output logic [PIX_W-1:0] mag,
  output logic             edge_bit,
  output logic [CNT_W-1:0] edge_count,
  output logic             edge_count_valid
);
  import sobel_pkg::*;

  stage_t               in_stage;
  stage_t [3:1]         vld_pipe;
  logic [SUM_W-1:0]     abs_x, abs_y;
  logic [GRAD_W-1:0]    s;
  logic [PIX_W-1:0]     sat;
  logic                 keep, hit;
  logic [CNT_W-1:0]     acc;

  assign in_stage = '{valid: in_valid, border: in_border, fstart: frame_start};

  sobel_axis u_x (
    .clk(clk), .rst(rst), .en(clk_en),
    .n0(pix_0), .n1(pix_3), .n2(pix_6),
    .p0(pix_2), .p1(pix_5), .p2(pix_8),
    .abs_g(abs_x)
  );

  sobel_axis u_y (
    .clk(clk), .rst(rst), .en(clk_en),
    .n0(pix_0), .n1(pix_1), .n2(pix_2),
    .p0(pix_6), .p1(pix_7), .p2(pix_8),
    .abs_g(abs_y)
  );

  assign s    = GRAD_W'(abs_x) + GRAD_W'(abs_y);
  assign sat  = (s > GRAD_W'(MAG_MAX)) ? PIX_W'(MAG_MAX) : s[PIX_W-1:0];
  assign keep = vld_pipe[2].valid & ~vld_pipe[2].border;

  // Flags ride alongside the data; stage 3 lines up with mag/edge_bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      mag      <= '0;
      edge_bit <= 1'b0;
    end else if (clk_en) begin
      vld_pipe <= {vld_pipe[2:1], in_stage};
      mag      <= keep ? sat : '0;
      edge_bit <= keep && (sat >= PIX_W'(THRESH));
    end
  end

  assign out_valid = vld_pipe[3].valid;
  assign hit       = out_valid & edge_bit;

  // A frame_start output pixel opens the new frame, so its own edge seeds acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc              <= '0;
      edge_count       <= '0;
      edge_count_valid <= 1'b0;
    end else if (clk_en) begin
      if (vld_pipe[3].fstart) begin
        edge_count       <= acc;
        edge_count_valid <= 1'b1;
        acc              <= CNT_W'(hit);
      end else begin
        edge_count_valid <= 1'b0;
        if (hit && acc != '1) acc <= acc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sobel_core.sv
// Scoreboard bench: driver queues spec-derived results, monitor pops one per enabled cycle.
module tb_sobel_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        in_valid = 1'b0, in_border = 1'b0, frame_start = 1'b0;
  logic [7:0]  pix [0:8];
  logic        out_valid, edge_bit, edge_count_valid;
  logic [7:0]  mag;
  logic [13:0] edge_count;

  typedef logic [8:0][7:0] win_t;
  typedef struct {
    bit v;
    int m;
    bit e;
    bit fs;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  bit   en_tog = 1'b1;
  int   stall_left = 0;
  int   seen_cnt = -1;

  sobel_core dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .in_border(in_border),
    .pix_0(pix[0]), .pix_1(pix[1]), .pix_2(pix[2]), .pix_3(pix[3]),
    .pix_5(pix[5]), .pix_6(pix[6]), .pix_7(pix[7]), .pix_8(pix[8]),
    .frame_start(frame_start), .out_valid(out_valid), .mag(mag), .edge_bit(edge_bit),
    .edge_count(edge_count), .edge_count_valid(edge_count_valid)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int px(int k);
    return int'(pix[k]);
  endfunction

  // Reference: plain Sobel arithmetic on the current window.
  function automatic exp_t model(bit v, bit b, bit fs);
    exp_t r;
    int gx, gy, s;
    gx = (px(2) + 2*px(5) + px(8)) - (px(0) + 2*px(3) + px(6));
    gy = (px(6) + 2*px(7) + px(8)) - (px(0) + 2*px(1) + px(2));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy;
    if (s > 255) s = 255;
    r.v  = v;
    r.fs = fs;
    r.m  = (v && !b) ? s : 0;
    r.e  = (v && !b) && (s >= 64);
    return r;
  endfunction

  function automatic win_t vert(int hi);
    win_t w = '0;
    w[2] = 8'(hi); w[5] = 8'(hi); w[8] = 8'(hi);
    return w;
  endfunction

  function automatic win_t flat(int val);
    win_t w;
    for (int k = 0; k < 9; k++) w[k] = 8'(val);
    return w;
  endfunction

  function automatic win_t rnd_win();
    win_t w;
    for (int k = 0; k < 9; k++) w[k] = 8'($urandom_range(255));
    return w;
  endfunction

  // Wait for the next negedge that leads into an enabled posedge, then present the sample.
  task automatic drive(bit v, bit b, bit fs, win_t w);
    do begin
      @(negedge clk);
      if (stall_left > 0) begin
        clk_en = 1'b0;
        stall_left--;
      end else begin
        clk_en = en_tog;
        en_tog = !en_tog;
      end
    end while (!clk_en);
    in_valid = v; in_border = b; frame_start = fs;
    for (int k = 0; k < 9; k++) pix[k] = w[k];
    q.push_back(model(v, b, fs));
  endtask

  task automatic flush(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rnd_win());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clk_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; en_tog = 1'b1;
    check("rst_edge_count", int'(edge_count), 0);
    check("rst_out_valid", int'(out_valid), 0);
  endtask

  // Monitor: output visible after each enabled edge is the sample two enabled edges earlier.
  initial begin
    exp_t z, cur;
    int acc, cnt;
    bit cv, r, e;
    z = '{v: 0, m: 0, e: 0, fs: 0};
    cur = z; acc = 0; cnt = 0; cv = 0;
    forever begin
      @(posedge clk);
      r = rst; e = clk_en;
      #1;
      if (r) begin
        q.delete();
        q.push_back(z); q.push_back(z);
        cur = z; acc = 0; cnt = 0; cv = 0;
      end else if (e) begin
        if (cur.fs) begin
          cnt = acc; cv = 1;
          acc = (cur.v && cur.e) ? 1 : 0;
        end else begin
          cv = 0;
          if (cur.v && cur.e && acc < 16383) acc++;
        end
        if (q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
          cur = z;
        end else cur = q.pop_front();
        if (edge_count_valid) seen_cnt = int'(edge_count);
      end
      check("out_valid", int'(out_valid), int'(cur.v));
      check("mag", int'(mag), cur.m);
      check("edge", int'(edge_bit), int'(cur.e));
      check("edge_count", int'(edge_count), cnt);
      check("edge_count_valid", int'(edge_count_valid), int'(cv));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 9; k++) pix[k] = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    drive(1, 0, 0, vert(255));
    drive(1, 0, 0, flat(100));
    drive(1, 0, 0, vert(10));
    drive(1, 0, 0, vert(16));
    drive(1, 0, 0, vert(15));
    drive(1, 1, 0, vert(255));
    drive(0, 0, 0, vert(255));
    flush(3);

    for (int i = 0; i < 12; i++) begin
      if (i == 5) stall_left = 5;
      drive(1, 0, 0, rnd_win());
    end
    flush(3);

    drive(1, 0, 1, flat(7));
    repeat (10) drive(1, 0, 0, vert(255));
    drive(1, 0, 1, vert(255));
    flush(4);
    check("frame_count_10", seen_cnt, 10);

    repeat (2) drive(1, 0, 0, vert(200));
    drive(1, 0, 1, flat(0));
    flush(4);
    check("frame_count_seeded", seen_cnt, 3);

    repeat (3) drive(1, 0, 0, vert(255));
    do_reset();
    repeat (4) drive(1, 0, 0, vert(255));
    flush(4);
    check("count_after_reset", int'(edge_count), 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 3) stall_left = $urandom_range(5, 1);
      drive($urandom_range(99) < 80, $urandom_range(99) < 10, $urandom_range(99) < 5,
            ($urandom_range(1) != 0) ? rnd_win() : vert($urandom_range(40)));
    end
    flush(4);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
